chaotic_slot_scheduler: RTL

Time-multiplexes `N_SLOTS` independent chaotic-system instances through one in-order, fully pipelined equation core of fixed latency `CORE_LAT`. It owns the per-slot state memory (x,y,z) and a writable per-slot parameter memory (a..e), and issues one slot per cycle. It feeds results back as the next state and streams every result out with its slot and iteration tags. It adds run control on top of the free-running ROM/RAM loop: seed/parameter load, start/stop, a bounded iteration count, and drain with a done indication.

---
 rtl/chaotic_pkg.sv | 30 +++
 rtl/chaotic_slot_ram.sv | 37 +++
 rtl/chaotic_slot_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/chaotic_pkg.sv
// Shared types, defaults and float constants for the chaotic-system slot scheduler.
// Also holds a constant-function log2 used to size counters and addresses.
package chaotic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } sched_state_t;

    localparam int DEFAULT_DATA_WIDTH = 64;

    localparam logic [63:0] TAO = 64'h3FD3333333333333;
    localparam logic [63:0] K0  = 64'h3FB999999999999A;
    localparam logic [63:0] K1  = 64'hC024000000000000;
    localparam logic [63:0] K2  = 64'h3FE0000000000000;

    function automatic int CLOG2(input int unsigned v);
        int unsigned t;
        int r;
        r = 0;
        t = (v > 1) ? v - 1 : 0;
        while (t > 0) begin
            r++;
            t = t >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/chaotic_slot_ram.sv
// Simple dual-port slot memory: one write port, one registered read port, read-first.
// Array contents are not reset; only the read register is cleared.
module chaotic_slot_ram
    import chaotic_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 256,
    parameter int AW    = CLOG2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking write above makes a same-edge read return the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/chaotic_slot_scheduler.sv
// Interleaves N_SLOTS chaotic-system instances through one in-order pipelined core,
// with seed/parameter load, bounded or free-running sweeps, stop and drain.
module chaotic_slot_scheduler
    import chaotic_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int N_SLOTS    = 245,
    parameter int ADDR_W     = 8,
    parameter int CORE_LAT   = 243,
    parameter int ITER_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [ITER_W-1:0]       iter_target,
    input  logic                    seed_we,
    input  logic                    par_we,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [3*DATA_WIDTH-1:0] seed_data,
    input  logic [5*DATA_WIDTH-1:0] par_data,
    output logic                    core_in_valid,
    output logic [3*DATA_WIDTH-1:0] core_xyz,
    output logic [5*DATA_WIDTH-1:0] core_par,
    input  logic                    core_out_valid,
    input  logic [3*DATA_WIDTH-1:0] core_xyz_n,
    output logic                    out_valid,
    output logic [ADDR_W-1:0]       out_slot,
    output logic [ITER_W-1:0]       out_iter,
    output logic [3*DATA_WIDTH-1:0] out_xyz,
    output logic                    busy,
    output logic                    done
);

    localparam int XYZ_W = 3 * DATA_WIDTH;
    localparam int PAR_W = 5 * DATA_WIDTH;
    localparam int INF_W = CLOG2(CORE_LAT + 2);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(N_SLOTS - 1);

    if (N_SLOTS < CORE_LAT + 2) begin : g_chk_lat
        $error("chaotic_slot_scheduler: N_SLOTS must be >= CORE_LAT+2");
    end
    if (N_SLOTS > (1 << ADDR_W)) begin : g_chk_addr
        $error("chaotic_slot_scheduler: N_SLOTS does not fit in ADDR_W bits");
    end

    sched_state_t state_q, state_d;

    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic [ITER_W-1:0] rd_sweep, wr_sweep, iter_tgt;
    logic [INF_W-1:0]  inflight;
    logic              stop_pend;

    logic              accept, issue, wrap, last_sweep, drain_empty, is_idle;
    logic              st_we;
    logic [ADDR_W-1:0] st_waddr;
    logic [XYZ_W-1:0]  st_wdata;

    always_comb begin
        state_d     = state_q;
        is_idle     = (state_q == ST_IDLE);
        accept      = is_idle && start && !stop;
        issue       = (state_q == ST_RUN);
        wrap        = issue && (rd_ptr == LAST_SLOT);
        last_sweep  = (iter_tgt != '0) && (ITER_W'(rd_sweep + 1'b1) == iter_tgt);
        drain_empty = (inflight == '0) && !core_in_valid && !core_out_valid;

        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_RUN;
            ST_RUN:   if (wrap && (stop_pend || stop || last_sweep)) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Core write-back owns the state port; seeds only land while idle.
        st_we    = core_out_valid || (is_idle && seed_we);
        st_waddr = core_out_valid ? wr_ptr : ld_addr;
        st_wdata = core_out_valid ? core_xyz_n : seed_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            rd_sweep      <= '0;
            wr_sweep      <= '0;
            iter_tgt      <= '0;
            inflight      <= '0;
            stop_pend     <= 1'b0;
            core_in_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_in_valid <= issue;
            busy          <= (state_d != ST_IDLE);
            done          <= (state_q == ST_DRAIN) && drain_empty;

            if (accept) begin
                rd_ptr    <= '0;
                rd_sweep  <= '0;
                wr_ptr    <= '0;
                wr_sweep  <= '0;
                iter_tgt  <= iter_target;
                stop_pend <= 1'b0;
            end else begin
                if (issue) begin
                    rd_ptr <= wrap ? '0 : rd_ptr + 1'b1;
                    if (wrap) rd_sweep <= rd_sweep + 1'b1;
                    if (stop) stop_pend <= 1'b1;
                end
                if (core_out_valid) begin
                    wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
                    if (wr_ptr == LAST_SLOT) wr_sweep <= wr_sweep + 1'b1;
                end
            end

            unique case ({core_in_valid, core_out_valid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_slot  <= '0;
            out_iter  <= '0;
            out_xyz   <= '0;
        end else begin
            out_valid <= core_out_valid;
            if (core_out_valid) begin
                out_slot <= wr_ptr;
                out_iter <= wr_sweep;
                out_xyz  <= core_xyz_n;
            end
        end
    end

    chaotic_slot_ram #(
        .WIDTH (XYZ_W),
        .DEPTH (N_SLOTS),
        .AW    (ADDR_W)
    ) u_state_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (st_we),
        .waddr (st_waddr),
        .wdata (st_wdata),
        .re    (issue),
        .raddr (rd_ptr),
        .rdata (core_xyz)
    );

    chaotic_slot_ram #(
        .WIDTH (PAR_W),
        .DEPTH (N_SLOTS),
        .AW    (ADDR_W)
    ) u_par_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (is_idle && par_we),
        .waddr (ld_addr),
        .wdata (par_data),
        .re    (issue),
        .raddr (rd_ptr),
        .rdata (core_par)
    );

endmodule
